// File: rtl/disp_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display: three pattern sources,
// minimum hold time per owner, and an all-blank gap between consecutive owners.
module disp_arbiter #(
   parameter int HOLD_CYCLES  = 16,
   parameter int BLANK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  req,
   input  logic [31:0] pats0,
   input  logic [31:0] pats1,
   input  logic [31:0] pats2,
   output logic [2:0]  gnt,
   output logic        switch_p,
   output logic        busy,
   output logic [7:0]  in0,
   output logic [7:0]  in1,
   output logic [7:0]  in2,
   output logic [7:0]  in3
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int GW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(BLANK_CYCLES - 1);
   localparam logic [31:0]   BLANK     = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      OWN,
      GAP
   } state_t;

   state_t         state_reg;
   logic [1:0]     owner_reg;
   logic [1:0]     last_reg;
   logic [HW-1:0]  hold_reg;
   logic [GW-1:0]  gap_reg;

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      case (idx)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] idx, input logic [31:0] p0,
                                        input logic [31:0] p1, input logic [31:0] p2);
      case (idx)
         2'd0:    return p0;
         2'd1:    return p1;
         default: return p2;
      endcase
   endfunction

   // Candidate gi is (last + gi + 1) mod 3, so the previous owner is searched last.
   logic [2:0][1:0] cand;
   logic [2:0]      cand_req;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cand
         logic [2:0] sum;
         assign sum          = {1'b0, last_reg} + 3'(gi + 1);
         assign cand[gi]     = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
         assign cand_req[gi] = |(req & onehot(cand[gi]));
      end
   endgenerate

   logic [1:0] win;
   logic       win_valid;
   logic       start_grant;
   logic       owner_req;
   logic       others_req;

   always_comb begin
      win_valid = |cand_req;
      if (cand_req[0]) begin
         win = cand[0];
      end else if (cand_req[1]) begin
         win = cand[1];
      end else begin
         win = cand[2];
      end
   end

   // gnt is one-hot on the owner throughout OWN, so it doubles as the owner mask.
   assign owner_req   = |(req & gnt);
   assign others_req  = |(req & ~gnt);
   assign start_grant = win_valid &&
                        ((state_reg == IDLE) || (state_reg == GAP && gap_reg == GAP_LAST));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         owner_reg <= 2'd0;
         last_reg  <= 2'd2;
         hold_reg  <= '0;
         gap_reg   <= '0;
         gnt       <= 3'b000;
         switch_p  <= 1'b0;
         busy      <= 1'b0;
         {in3, in2, in1, in0} <= BLANK;
      end else begin
         switch_p <= 1'b0;
         if (start_grant) begin
            state_reg <= OWN;
            owner_reg <= win;
            last_reg  <= win;
            hold_reg  <= '0;
            gap_reg   <= '0;
            gnt       <= onehot(win);
            switch_p  <= 1'b1;
            busy      <= 1'b1;
            {in3, in2, in1, in0} <= pick(win, pats0, pats1, pats2);
         end else begin
            case (state_reg)
               IDLE: begin
                  gnt  <= 3'b000;
                  busy <= 1'b0;
                  {in3, in2, in1, in0} <= BLANK;
               end
               OWN: begin
                  // Voluntary release wins over the hold time; pre-emption waits for it.
                  if (!owner_req || (hold_reg == HOLD_LAST && others_req)) begin
                     state_reg <= GAP;
                     gap_reg   <= '0;
                     gnt       <= 3'b000;
                     {in3, in2, in1, in0} <= BLANK;
                  end else begin
                     if (hold_reg != HOLD_LAST) begin
                        hold_reg <= hold_reg + HW'(1);
                     end
                     {in3, in2, in1, in0} <= pick(owner_reg, pats0, pats1, pats2);
                  end
               end
               GAP: begin
                  if (gap_reg == GAP_LAST) begin
                     state_reg <= IDLE;
                     gap_reg   <= '0;
                     busy      <= 1'b0;
                  end else begin
                     gap_reg <= gap_reg + GW'(1);
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  gnt       <= 3'b000;
                  busy      <= 1'b0;
                  {in3, in2, in1, in0} <= BLANK;
               end
            endcase
         end
      end
   end

endmodule
